// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types, constants and parameter helpers for pwm_capture
//
// Purpose : FSM state encoding and clock-to-microsecond helpers used by the
//           PWM capture block. Parameter legality helpers are evaluated at
//           elaboration time by pwm_capture.
// Ports   : none (package)

package pwm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,   // waiting for the arming rise
      HIGH = 2'd1,   // between a rise and its fall
      LOW  = 2'd2    // between a fall and the closing rise
   } pwm_state_t;

   localparam int NS_PER_US = 1000;

   // Clocks per microsecond for a given clock period.
   function automatic int ticks_per_us(input int clk_period_ns);
      return NS_PER_US / clk_period_ns;
   endfunction

   // Clock period must divide one microsecond exactly and give at least two
   // ticks; the prescaler restarts at 1 on a rise, which needs TPU >= 2.
   function automatic bit clk_period_ok(input int clk_period_ns);
      return (clk_period_ns > 0) &&
             ((NS_PER_US % clk_period_ns) == 0) &&
             ((NS_PER_US / clk_period_ns) >= 2);
   endfunction

   // Timeout must be non-zero and representable in the us counter.
   function automatic bit timeout_ok(input int timeout_us, input int data_width);
      longint max_cnt;
      max_cnt = (longint'(1) << data_width) - 1;
      return (timeout_us >= 1) && (longint'(timeout_us) <= max_cnt);
   endfunction

endpackage

// File: rtl/pwm_edge_detect.sv
// rtl/pwm_edge_detect.sv - pwm_in synchroniser with rise/fall detection
//
// Purpose : Brings the asynchronous PWM input into the clk domain through
//           SYNC_STAGES flops plus one history flop and flags edges.
// Ports   : clk    - system clock
//           rst    - synchronous active-high reset
//           pwm_in - asynchronous PWM input
//           level  - synchronised level of pwm_in
//           rise   - one-cycle pulse on a synchronised 0->1 transition
//           fall   - one-cycle pulse on a synchronised 1->0 transition

module pwm_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic pwm_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   // vld_q[i] marks that sync_q[i] (or prev_q for i == SYNC_STAGES) holds a
   // real sample of pwm_in rather than the reset zero. Without it, a line that
   // is high when rst is released would look like a rise and arm the FSM on a
   // partial cycle.
   logic [SYNC_STAGES:0]   vld_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         vld_q  <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
         prev_q <= sync_q[SYNC_STAGES-1];
         vld_q  <= {vld_q[SYNC_STAGES-1:0], 1'b1};
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = vld_q[SYNC_STAGES] &  level & ~prev_q;
   assign fall  = vld_q[SYNC_STAGES] & ~level &  prev_q;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period / high-time measurement in microseconds
//
// Purpose : Measures each PWM cycle of pwm_in: period (rise to rise) and high
//           time (rise to fall), both truncated to whole microseconds, and
//           flags loss of toggling after TIMEOUT_US without a rise.
// Ports   : clk            - system clock
//           rst            - synchronous active-high reset
//           pwm_in         - asynchronous PWM input
//           pwm_period     - last measured period, us
//           pwm_duty_cycle - last measured high time, us
//           meas_valid     - one-cycle pulse when the measurement updates
//           signal_lost    - set on timeout, cleared by the next meas_valid

module pwm_capture
   import pwm_pkg::*;
#(
   parameter int CLK_PERIOD  = 10,
   parameter int DATA_WIDTH  = 16,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_US  = 1000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pwm_in,
   output logic [DATA_WIDTH-1:0] pwm_period,
   output logic [DATA_WIDTH-1:0] pwm_duty_cycle,
   output logic                  meas_valid,
   output logic                  signal_lost
);

   localparam int TPU = ticks_per_us(CLK_PERIOD);
   localparam int PW  = $clog2(TPU);

   localparam logic [PW-1:0]         PRE_LAST = PW'(TPU - 1);
   localparam logic [DATA_WIDTH-1:0] US_LIMIT = DATA_WIDTH'(TIMEOUT_US);

   if (!clk_period_ok(CLK_PERIOD)) begin : g_bad_clk_period
      $error("pwm_capture: CLK_PERIOD must divide 1000 with a quotient of at least 2");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync_stages
      $error("pwm_capture: SYNC_STAGES must be at least 2");
   end
   if (!timeout_ok(TIMEOUT_US, DATA_WIDTH)) begin : g_bad_timeout
      $error("pwm_capture: TIMEOUT_US must be in 1 .. 2^DATA_WIDTH-1");
   end

   // Edge detection
   logic level_unused;   // measurement works purely on edges
   logic rise;
   logic fall;

   pwm_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_edge (
      .clk    (clk),
      .rst    (rst),
      .pwm_in (pwm_in),
      .level  (level_unused),
      .rise   (rise),
      .fall   (fall)
   );

   // State and counters
   pwm_state_t            state_q;
   pwm_state_t            state_d;
   logic [PW-1:0]         pre_q;      // elapsed clocks mod TPU
   logic [DATA_WIDTH-1:0] us_q;       // elapsed whole microseconds
   logic [DATA_WIDTH-1:0] shadow_q;   // high time of the cycle in progress

   logic timeout;
   logic restart;
   logic take_duty;
   logic take_meas;
   logic lost_set;

   assign timeout = (us_q == US_LIMIT);

   always_comb begin
      state_d   = state_q;
      restart   = 1'b0;
      take_duty = 1'b0;
      take_meas = 1'b0;
      lost_set  = 1'b0;
      case (state_q)
         IDLE: begin
            if (rise) begin
               restart = 1'b1;
               state_d = HIGH;
            end
         end
         HIGH: begin
            // A rise here cannot follow a real fall; treat it as a fresh
            // arming point rather than producing a measurement.
            if (rise) begin
               restart = 1'b1;
            end else if (timeout) begin
               lost_set = 1'b1;
               state_d  = IDLE;
            end else if (fall) begin
               take_duty = 1'b1;
               state_d   = LOW;
            end
         end
         LOW: begin
            // The rise is checked first so that a rise landing exactly on the
            // timeout count still closes a valid measurement.
            if (rise) begin
               take_meas = 1'b1;
               restart   = 1'b1;
               state_d   = HIGH;
            end else if (timeout) begin
               lost_set = 1'b1;
               state_d  = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // The rise cycle itself is elapsed count 0, so the cycle after it is 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q <= '0;
         us_q  <= '0;
      end else if (restart) begin
         pre_q <= PW'(1);
         us_q  <= '0;
      end else if (state_d != IDLE) begin
         if (pre_q == PRE_LAST) begin
            pre_q <= '0;
            us_q  <= us_q + DATA_WIDTH'(1);
         end else begin
            pre_q <= pre_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q <= '0;
      end else if (take_duty) begin
         shadow_q <= us_q;
      end
   end

   // Outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_period     <= '0;
         pwm_duty_cycle <= '0;
         meas_valid     <= 1'b0;
         signal_lost    <= 1'b0;
      end else begin
         meas_valid <= take_meas;
         if (take_meas) begin
            pwm_period     <= us_q;
            pwm_duty_cycle <= shadow_q;
            signal_lost    <= 1'b0;
         end else if (lost_set) begin
            signal_lost <= 1'b1;
         end
      end
   end

endmodule
